seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Time-multiplexed seven-segment display scan controller. Owns the digit-select counter
//   and its prescaler, and snapshots a hex word once per frame. Drives active-low anode and
//   segment lines, with a per-slot dead time to suppress ghosting. Sits between the
//   numeric datapath and the board display pins.
// PARAMETERS
//   NUM_DIGITS  8       digits scanned, legal 2..8 (digit index is 3 bits)
//   TICK_DIV    100000  clk cycles per digit slot, >= BLANK_CYC+2
//   BLANK_CYC   16      dead-time cycles at start of each slot, >= 1
// PORTS
//   clk         in   1             system clock
//   rst         in   1             asynchronous, active-high reset
//   en          in   1             scan enable; 0 = display dark, counters held at 0
//   digits_in   in   4*NUM_DIGITS  hex nibbles, digit i = [4i+3:4i], digit 0 rightmost
//   dp_in       in   NUM_DIGITS    decimal point per digit, 1 = lit
//   digit_mask  in   NUM_DIGITS    1 = digit may be driven; 0 = always dark
//   lz_blank    in   1             1 = blank leading zeros (digit 0 never blanked)
//   an          out  NUM_DIGITS    anode select, active-low, at most one low
//   seg         out  7             {g,f,e,d,c,b,a}, active-low
//   dp          out  1             decimal point, active-low
//   digit_idx   out  3             index of the current slot
//   frame_start out  1             1-cycle pulse on the first cycle of each frame
// BEHAVIOUR
//   Reset: an all 1, seg 7'h7F, dp 1, digit_idx 0, frame_start 0, prescaler p 0, FSM IDLE,
//     snapshot 0. Reset mid-scan aborts immediately; no partial slot completes.
//   FSM states: IDLE, BLANK, DRIVE.
//     IDLE: en=0. p and idx held at 0. en=1 -> BLANK, and the frame starts this cycle.
//     BLANK: p < BLANK_CYC. Outputs dark. -> DRIVE when p == BLANK_CYC-1.
//     DRIVE: p >= BLANK_CYC. -> BLANK at p == TICK_DIV-1 (slot tick).
//     Any state with en=0 -> IDLE next cycle, with p and idx cleared.
//   Prescaler: p counts 0..TICK_DIV-1 while en=1, then wraps to 0.
//     On the wrap, idx increments; at NUM_DIGITS-1 it wraps to 0.
//   frame_start: high when en=1, p==0, idx==0, including the first cycle after enable.
//     On that same cycle, digits_in, dp_in, digit_mask and lz_blank load into the snapshot.
//     The snapshot is used from the next cycle. Input changes mid-frame are invisible.
//   Leading-zero rule, evaluated on the snapshot: digit i>0 is blanked iff lz_blank=1 and
//     nibbles i..NUM_DIGITS-1 are all 0. A blanked digit shows no segments and no dp.
//   Digit lit iff state DRIVE, mask[idx]=1 and digit not LZ-blanked. A lit digit drives:
//     an[idx]=0, seg=hex7(nibble[idx]), dp=~dp_in[idx]. An unlit digit drives an all 1,
//     seg 7'h7F, dp 1.
//   hex7 table (active-low {g..a}):
//     0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//   Output latency: an, seg and dp are registered. The value at cycle t+1 reflects
//     state, p and idx at cycle t.
//   digit_idx and frame_start are registered with the same 1-cycle latency.
//   Frame period is NUM_DIGITS*TICK_DIV cycles.
//   Each digit is driven for TICK_DIV-BLANK_CYC cycles per frame.
//   Anodes never overlap: the slot change always passes through BLANK, >= 1 dark cycle.
// TESTING (bench params NUM_DIGITS=4, TICK_DIV=8, BLANK_CYC=2)
//   1 Assert rst mid-DRIVE -> same cycle an=4'hF, seg=7'h7F, dp=1; release with en=1
//     -> frame_start on the first edge after release.
//   2 en=1, digits_in=16'h1234, mask=4'hF, lz_blank=0 -> slot0: 2 dark cycles, then
//     an=4'b1110, seg=7'h19 for 6 cycles; slot3 seg=7'h79; frame_start every 32 cycles.
//   3 digits_in=16'h0050, lz_blank=1 -> an[3] and an[2] stay 1 for the whole frame;
//     digit1 seg=7'h12; digit0 seg=7'h40.
//   4 Change digits_in from 16'h1234 to 16'hABCD mid-frame -> displayed values unchanged
//     until the next frame_start; next frame digit0 seg=7'h21.
//   5 Drop en mid-DRIVE of slot2 -> outputs dark within 2 cycles and digit_idx=0;
//     re-raise en -> frame_start, slot0 restarts with 2 dark cycles.
//   6 mask=4'b0101 over 3 frames -> an is only ever 4'hF, 4'b1110 or 4'b1011, and never
//     has two bits low.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: prescaled digit scan with per-slot dead time,
// per-frame input snapshot, leading-zero blanking and registered active-low outputs.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 100000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_mask,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [2:0]              digit_idx,
    output logic                    frame_start,
    output logic [1:0]              o_dbg_state
);

    localparam int              PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   P_LAST       = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   P_BLANK_LAST = PW'(BLANK_CYC - 1);
    localparam logic [2:0]      IDX_LAST     = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [PW-1:0]           r_p, w_p_nxt;
    logic [2:0]              r_idx, w_idx_nxt;
    logic                    w_slot_tick;
    logic                    w_frame_cyc;

    logic [4*NUM_DIGITS-1:0] r_snap_dig;
    logic [NUM_DIGITS-1:0]   r_snap_dp;
    logic [NUM_DIGITS-1:0]   r_snap_mask;
    logic                    r_snap_lz;

    logic [31:0]             w_dig32;
    logic [7:0]              w_dp8;
    logic [7:0]              w_mask8;
    logic [7:0]              w_lz;
    logic                    w_upper_zero;
    logic [3:0]              w_nib;
    logic                    w_lit;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic [6:0]              w_seg_nxt;
    logic                    w_dp_nxt;

    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [2:0]              r_digit_idx;
    logic                    r_frame_start;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        w_slot_tick = (r_p == P_LAST);
        w_frame_cyc = en && (r_p == '0) && (r_idx == 3'd0);
        w_state_nxt = S_IDLE;
        w_p_nxt     = '0;
        w_idx_nxt   = 3'd0;
        if (en) begin
            w_p_nxt     = w_slot_tick ? '0 : r_p + 1'b1;
            w_idx_nxt   = !w_slot_tick ? r_idx : ((r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1);
            w_state_nxt = r_state;
            case (r_state)
                // The enabling cycle is already p=0 of the frame's first slot.
                S_IDLE:  w_state_nxt = (BLANK_CYC > 1) ? S_BLANK : S_DRIVE;
                S_BLANK: if (r_p == P_BLANK_LAST) w_state_nxt = S_DRIVE;
                S_DRIVE: if (w_slot_tick) w_state_nxt = S_BLANK;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap_dig  <= '0;
            r_snap_dp   <= '0;
            r_snap_mask <= '0;
            r_snap_lz   <= 1'b0;
        end else if (w_frame_cyc) begin
            r_snap_dig  <= digits_in;
            r_snap_dp   <= dp_in;
            r_snap_mask <= digit_mask;
            r_snap_lz   <= lz_blank;
        end
    end

    // Snapshot is zero-padded to 8 digits so the 3-bit index never runs off the end.
    always_comb begin
        w_dig32                         = '0;
        w_dig32[4*NUM_DIGITS-1:0]       = r_snap_dig;
        w_dp8                           = '0;
        w_dp8[NUM_DIGITS-1:0]           = r_snap_dp;
        w_mask8                         = '0;
        w_mask8[NUM_DIGITS-1:0]         = r_snap_mask;
        w_lz                            = '0;
        w_upper_zero                    = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            w_upper_zero = w_upper_zero && (w_dig32[4*i +: 4] == 4'd0);
            w_lz[i]      = r_snap_lz && w_upper_zero && (i != 0);
        end
        w_nib     = w_dig32[{r_idx, 2'b00} +: 4];
        w_lit     = (r_state == S_DRIVE) && w_mask8[r_idx] && !w_lz[r_idx];
        w_an_nxt  = '1;
        w_seg_nxt = 7'h7F;
        w_dp_nxt  = 1'b1;
        if (w_lit) begin
            w_an_nxt  = ~(NUM_DIGITS'(1) << r_idx);
            w_seg_nxt = hex7(w_nib);
            w_dp_nxt  = ~w_dp8[r_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an          <= '1;
            r_seg         <= 7'h7F;
            r_dp          <= 1'b1;
            r_digit_idx   <= 3'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_an          <= w_an_nxt;
            r_seg         <= w_seg_nxt;
            r_dp          <= w_dp_nxt;
            r_digit_idx   <= r_idx;
            r_frame_start <= w_frame_cyc;
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign digit_idx   = r_digit_idx;
    assign frame_start = r_frame_start;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus randomized segments, all checked
// cycle by cycle against a position-in-frame reference model.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int TICK  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = N * TICK;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [15:0]  digits_in = '0;
    logic [3:0]   dp_in = '0;
    logic [3:0]   digit_mask = '0;
    logic         lz_blank = 1'b0;
    logic [3:0]   an;
    logic [6:0]   seg;
    logic         dp;
    logic [2:0]   digit_idx;
    logic         frame_start;
    logic [1:0]   o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position within the frame plus the per-frame snapshot.
    int           m_pos = 0;
    logic [15:0]  m_dig = '0;
    logic [3:0]   m_dp = '0;
    logic [3:0]   m_mask = '0;
    logic         m_lz = 1'b0;
    logic [6:0]   hex7_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [15:0]  exp_q [$];

    seg_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(TICK), .BLANK_CYC(BLANK)) dut (
        .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
        .digit_mask(digit_mask), .lz_blank(lz_blank), .an(an), .seg(seg), .dp(dp),
        .digit_idx(digit_idx), .frame_start(frame_start), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask

    // Expected outputs after this edge, from the model state before the edge.
    task automatic model_step();
        int         slot, ph;
        logic [15:0] shifted;
        logic       lit;
        logic [3:0] onehot, e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        slot    = m_pos / TICK;
        ph      = m_pos % TICK;
        shifted = m_dig >> (4 * slot);
        lit     = (ph >= BLANK) && m_mask[slot] && !(slot > 0 && m_lz && shifted == 16'd0);
        onehot  = 4'b0001 << slot;
        e_an    = lit ? ~onehot : 4'hF;
        e_seg   = lit ? hex7_tbl[shifted[3:0]] : 7'h7F;
        e_dp    = lit ? ~m_dp[slot] : 1'b1;
        exp_q.push_back({e_an, e_seg, e_dp, 3'(slot), (en && m_pos == 0)});
        if (en && m_pos == 0) begin
            m_dig  = digits_in;
            m_dp   = dp_in;
            m_mask = digit_mask;
            m_lz   = lz_blank;
        end
        m_pos = en ? (m_pos + 1) % FRAME : 0;
    endtask

    task automatic step(input int n);
        logic [15:0] e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            #1;
            e = exp_q.pop_front();
            check_eq("an", 32'(an), 32'(e[15:12]));
            check_eq("seg", 32'(seg), 32'(e[11:5]));
            check_eq("dp", 32'(dp), 32'(e[4]));
            check_eq("digit_idx", 32'(digit_idx), 32'(e[3:1]));
            check_eq("frame_start", 32'(frame_start), 32'(e[0]));
            check_eq("an_onehot", 32'($countones(~an) <= 1), 32'd1);
        end
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_dig  = '0;
        m_dp   = '0;
        m_mask = '0;
        m_lz   = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_dark(input string tag);
        check_eq({tag, "_an"}, 32'(an), 32'hF);
        check_eq({tag, "_seg"}, 32'(seg), 32'h7F);
        check_eq({tag, "_dp"}, 32'(dp), 32'd1);
        check_eq({tag, "_idx"}, 32'(digit_idx), 32'd0);
        check_eq({tag, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    initial begin
        #23;
        check_dark("reset");
        @(negedge clk);
        rst = 1'b0;
        step(3);

        // Plain scan of 1234, then a mid-frame change that must wait for the next frame.
        digits_in = 16'h1234; digit_mask = 4'hF; lz_blank = 1'b0; dp_in = 4'b0010;
        en = 1'b1;
        step(FRAME + 10);
        digits_in = 16'hABCD;
        step(FRAME + 12);

        // Asynchronous reset while a digit is being driven.
        while (m_pos % TICK < BLANK + 1) step(1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_dark("rst_mid");
        model_reset();
        @(negedge clk);
        digits_in = 16'h0050; lz_blank = 1'b1; dp_in = 4'b1111; en = 1'b1;
        rst = 1'b0;
        step(2 * FRAME);

        // Drop enable in the middle of slot 2, then restart.
        digits_in = 16'h8765; lz_blank = 1'b0; dp_in = 4'b0100;
        while (m_pos != 2 * TICK + BLANK + 2) step(1);
        en = 1'b0;
        step(3);
        en = 1'b1;
        step(TICK + 4);

        // Sparse mask over several frames.
        digit_mask = 4'b0101;
        step(3 * FRAME);

        // Randomized segments.
        for (int s = 0; s < 24; s++) begin
            digits_in  = 16'($urandom);
            if ($urandom_range(0, 2) == 0) digits_in = digits_in & 16'h00FF;
            dp_in      = 4'($urandom);
            digit_mask = 4'($urandom);
            lz_blank   = 1'($urandom);
            en         = ($urandom_range(0, 9) != 0);
            step($urandom_range(1, 40));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
